// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter/rotator: one register slot per shift stage (2^k at stage k), valid/ready on both sides.
// Optional carry-out path is enabled by defining BARREL_SHIFTER_CARRY_EN.
module barrel_shifter_pipe #(
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [$clog2(WIDTH)-1:0]  in_shamt,
  input  logic [2:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data
`ifdef BARREL_SHIFTER_CARRY_EN
  ,
  output logic                      out_carry
`endif
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int LAST    = SHAMT_W - 1;

  localparam logic [2:0] M_ROL = 3'b001;
  localparam logic [2:0] M_SRL = 3'b010;
  localparam logic [2:0] M_SLL = 3'b011;
  localparam logic [2:0] M_SRA = 3'b100;

  // Stage k keeps only the shamt bits later stages still need, packed into one flat vector.
  function automatic int sh_off(int k);
    int o;
    o = 0;
    for (int j = 0; j < k; j++) o += SHAMT_W - 1 - j;
    return o;
  endfunction

  localparam int SH_BITS = sh_off(LAST);

  logic [LAST:0]              vld_pipe, adv, load;
  logic [LAST:0][WIDTH-1:0]   data_q, data_d;
  logic [LAST-1:0][2:0]       md_q, md_d;
  logic [SH_BITS-1:0]         sh_q, sh_d, sh_ld;
`ifdef BARREL_SHIFTER_CARRY_EN
  logic [LAST:0]              carry_q, carry_d;
`endif

  for (genvar k = 0; k <= LAST; k++) begin : g_stg
    localparam int A  = 1 << k;
    localparam int RW = SHAMT_W - k;
    logic [WIDTH-1:0] d_in, d_shift;
    logic [RW-1:0]    sh_in;
    logic [2:0]       md_in;
`ifdef BARREL_SHIFTER_CARRY_EN
    logic             c_in, c_shift;
`endif

    if (k == 0) begin : g_src
      assign d_in  = in_data;
      assign sh_in = in_shamt;
      assign md_in = in_mode;
`ifdef BARREL_SHIFTER_CARRY_EN
      assign c_in  = 1'b0;
`endif
    end else begin : g_src
      assign d_in  = data_q[k-1];
      assign sh_in = sh_q[sh_off(k-1) +: RW];
      assign md_in = md_q[k-1];
`ifdef BARREL_SHIFTER_CARRY_EN
      assign c_in  = carry_q[k-1];
`endif
    end

    if (k < LAST) begin : g_fwd
      assign sh_d[sh_off(k) +: RW-1]  = sh_in[RW-1:1];
      assign sh_ld[sh_off(k) +: RW-1] = {(RW-1){load[k]}};
      assign md_d[k]                  = md_in;
    end

    always_comb begin
      case (md_in)
        M_ROL:   d_shift = (d_in << A) | (d_in >> (WIDTH - A));
        M_SRL:   d_shift = d_in >> A;
        M_SLL:   d_shift = d_in << A;
        M_SRA:   d_shift = $signed(d_in) >>> A;
        default: d_shift = (d_in >> A) | (d_in << (WIDTH - A));
      endcase
    end

    assign data_d[k] = sh_in[0] ? d_shift : d_in;

`ifdef BARREL_SHIFTER_CARRY_EN
    // Stages run in ascending order, so the last stage that shifts leaves the overall last-out bit.
    always_comb begin
      case (md_in)
        M_ROL:        c_shift = d_shift[0];
        M_SRL, M_SRA: c_shift = d_in[A-1];
        M_SLL:        c_shift = d_in[WIDTH-A];
        default:      c_shift = d_shift[WIDTH-1];
      endcase
    end

    assign carry_d[k] = sh_in[0] ? c_shift : c_in;
`endif
  end

  // A stage moves when any slot downstream of it is empty or the output retires.
  always_comb begin
    adv = '0;
    for (int k = 0; k <= LAST; k++) begin
      adv[k] = vld_pipe[k] && out_ready;
      for (int j = k + 1; j <= LAST; j++)
        if (!vld_pipe[j]) adv[k] = vld_pipe[k];
    end
    in_ready = !vld_pipe[0] || adv[0];
    load     = '0;
    load[0]  = in_valid && in_ready;
    for (int k = 1; k <= LAST; k++) load[k] = adv[k-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      data_q   <= '0;
      md_q     <= '0;
      sh_q     <= '0;
`ifdef BARREL_SHIFTER_CARRY_EN
      carry_q  <= '0;
`endif
    end else begin
      for (int k = 0; k <= LAST; k++) begin
        if (load[k]) begin
          vld_pipe[k] <= 1'b1;
          data_q[k]   <= data_d[k];
`ifdef BARREL_SHIFTER_CARRY_EN
          carry_q[k]  <= carry_d[k];
`endif
        end else if (adv[k]) begin
          vld_pipe[k] <= 1'b0;
        end
      end
      for (int k = 0; k < LAST; k++)
        if (load[k]) md_q[k] <= md_d[k];
      for (int b = 0; b < SH_BITS; b++)
        if (sh_ld[b]) sh_q[b] <= sh_d[b];
    end
  end

  assign out_valid = vld_pipe[LAST];
  assign out_data  = data_q[LAST];
`ifdef BARREL_SHIFTER_CARRY_EN
  assign out_carry = carry_q[LAST];
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe (WIDTH=32): bit-level reference model, scoreboard monitor, directed and random phases.
module tb_barrel_shifter_pipe;
  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [SW-1:0] in_shamt;
  logic [2:0]    in_mode;
`ifdef BARREL_SHIFTER_CARRY_EN
  logic          out_carry;
`endif

  always #5 clk = ~clk;

  barrel_shifter_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef BARREL_SHIFTER_CARRY_EN
    , .out_carry(out_carry)
`endif
  );

  typedef struct { logic [31:0] d; logic c; } exp_t;
  exp_t q[$];
  int nchk = 0, nerr = 0, cyc = 0, n_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: each output bit picked straight from the rule for its mode; returns {carry, data}.
  function automatic logic [32:0] model(input int w, input logic [31:0] d, input int s, input logic [2:0] m);
    logic [31:0] o;
    logic c;
    o = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        3'd1:    o[i] = d[(i - s + w) % w];
        3'd2:    o[i] = (i + s < w) ? d[i + s] : 1'b0;
        3'd3:    o[i] = (i >= s) ? d[i - s] : 1'b0;
        3'd4:    o[i] = (i + s < w) ? d[i + s] : d[w - 1];
        default: o[i] = d[(i + s) % w];
      endcase
    end
    if (s == 0) c = 1'b0;
    else case (m)
      3'd1:       c = o[0];
      3'd2, 3'd4: c = d[s - 1];
      3'd3:       c = d[w - s];
      default:    c = o[w - 1];
    endcase
    return {c, o};
  endfunction

  // Monitor samples 1 time unit after the falling edge; what it sees transfers on the next rising edge.
  logic        stalled = 1'b0;
  logic [31:0] held_d;
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, held_d);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_output: got %0h expected none", out_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_data", out_data, e.d);
`ifdef BARREL_SHIFTER_CARRY_EN
          chk("sb_carry", out_carry, e.c);
`endif
          n_out++;
        end
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      if (in_valid && in_ready) begin
        logic [32:0] r;
        exp_t e;
        r   = model(W, in_data, int'(in_shamt), in_mode);
        e.d = r[31:0];
        e.c = r[32];
        q.push_back(e);
      end
    end
  end

  // A beat presented in cycle c must be visible on the output in cycle c+SW.
  task automatic directed(input logic [31:0] d, input int s, input logic [2:0] m,
                          input logic [31:0] ed, input logic ec, input string nm);
    int c0;
    bit seen;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_shamt = SW'(s); in_mode = m; out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, in_ready, 1'b1);
    c0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < SW + 3 && !seen; i++) begin
      #1;
      if (out_valid) begin
        seen = 1;
        chk({nm, "_latency"}, cyc - c0, SW);
        chk({nm, "_data"}, out_data, ed);
`ifdef BARREL_SHIFTER_CARRY_EN
        chk({nm, "_carry"}, out_carry, ec);
`endif
      end else @(negedge clk);
    end
    if (!seen) begin
      nchk++; nerr++;
      $display("FAIL %s_timeout: got no output expected %0h", nm, ed);
    end
  endtask

  task automatic run_random(input int n, input int pv, input int pr);
    int sent = 0, guard = 0;
    bit fired = 0;
    in_valid = 1'b0;
    while (sent < n && guard < 60000) begin
      @(negedge clk);
      guard++;
      if (!in_valid || fired) begin
        in_valid = ($urandom_range(99) < pv);
        in_data  = $urandom;
        in_shamt = SW'($urandom);
        in_mode  = 3'($urandom);
      end
      out_ready = ($urandom_range(99) < pr);
      #1;
      fired = in_valid && in_ready;
      if (fired) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("random_sent", sent, n);
  endtask

  initial begin
    int sent, base;
    bit fired;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
`ifdef BARREL_SHIFTER_CARRY_EN
    chk("rst_out_carry", out_carry, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);

    chk("pin_ror8",  model(8, 32'h96, 3, 3'd0),        {1'b1, 32'h000000D2});
    chk("pin_rol8",  model(8, 32'h81, 1, 3'd1),        {1'b1, 32'h00000003});
    chk("pin_rol8z", model(8, 32'h5A, 0, 3'd1),        {1'b0, 32'h0000005A});
    chk("pin_sra",   model(32, 32'h80000001, 4, 3'd4), {1'b0, 32'hF8000000});
    chk("pin_sll",   model(32, 32'h000000FF, 28, 3'd3), {1'b1, 32'hF0000000});
    chk("pin_srl",   model(32, 32'h80000000, 31, 3'd2), {1'b0, 32'h00000001});

    directed(32'h80000001, 4,  3'd4, 32'hF8000000, 1'b0, "sra4");
    directed(32'h000000FF, 28, 3'd3, 32'hF0000000, 1'b1, "sll28");
    directed(32'h80000000, 31, 3'd2, 32'h00000001, 1'b0, "srl31");
    directed(32'h00000096, 3,  3'd0, 32'hC0000012, 1'b1, "ror3");
    directed(32'h00000081, 1,  3'd1, 32'h00000102, 1'b0, "rol1");
    directed(32'h0000005A, 0,  3'd1, 32'h0000005A, 1'b0, "rol0");
    directed(32'h12345678, 7,  3'd6, 32'hF02468AC, 1'b1, "mode6_ror");

    // Stall: out_ready low for local cycles 2..8 while 10 beats are offered back to back.
    sent = 0; fired = 0;
    for (int i = 0; sent < 10 && i < 200; i++) begin
      @(negedge clk);
      out_ready = !(i >= 2 && i <= 8);
      if (i == 0 || fired) begin
        in_valid = 1'b1; in_data = $urandom; in_shamt = SW'($urandom); in_mode = 3'($urandom);
      end
      #1;
      if (i == 8) begin
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_held", sent, SW);
      end
      fired = in_valid && in_ready;
      if (fired) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stall_sent", sent, 10);
    repeat (SW + 2) @(negedge clk);

    // Full rate: 64 beats in 64 cycles, all out by cycle 63+SW.
    sent = 0; base = n_out;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = $urandom; in_shamt = SW'($urandom); in_mode = 3'($urandom); out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("thru_accepted", sent, 64);
    repeat (SW - 1) @(negedge clk);
    #3;
    chk("thru_out", n_out - base, 64);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = $urandom | 32'h1; in_shamt = SW'(i); in_mode = 3'd0; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_out_data", out_data, 32'h0);
    chk("flush_in_ready", in_ready, 1'b1);
    directed(32'hA5A5A5A5, 16, 3'd3, 32'hA5A50000, 1'b1, "post_rst");

    run_random(10000, 70, 70);

    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    #3;
    chk("drain_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
